// File: rtl/tanh_4bit_preact_accum.sv
// tanh_4bit_preact_accum
// Accumulates N_TERMS products of an unsigned 4-bit activation and a signed
// 4-bit weight, then shifts and saturates the sum into a 4-bit two's-complement
// code that drives a downstream 4-bit tanh stage. A two-state handshake
// (ACC collecting, HOLD presenting) separates the term stream from the result.
module tanh_4bit_preact_accum #(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 10,
  parameter int SHIFT   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] x,
  input  logic [3:0] w,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_code
);

  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TERMS - 1);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                   state;
  logic        [CNT_W-1:0]  count;
  logic signed [ACC_W-1:0]  acc;

  logic signed [7:0]        x_ext;
  logic signed [7:0]        w_ext;
  logic signed [7:0]        prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  shifted;
  logic                     pos_ovf;
  logic                     neg_ovf;
  logic        [3:0]        sat_code;
  logic                     take_term;
  logic                     last_term;

  // x is zero-extended so it stays non-negative; w is sign-extended. The
  // product magnitude never exceeds 120, so 8 signed bits hold it exactly.
  assign x_ext    = {4'b0000, x};
  assign w_ext    = {{4{w[3]}}, w};
  assign prod     = x_ext * w_ext;
  assign prod_ext = {{(ACC_W-8){prod[7]}}, prod};
  assign sum      = acc + prod_ext;
  assign shifted  = sum >>> SHIFT;

  // The shifted value fits in 4 bits only when every bit from bit 3 up
  // matches the sign bit; otherwise clamp toward the side the sign indicates.
  assign pos_ovf  = ~shifted[ACC_W-1] & (|shifted[ACC_W-2:3]);
  assign neg_ovf  =  shifted[ACC_W-1] & ~(&shifted[ACC_W-2:3]);
  assign sat_code = pos_ovf ? 4'b0111 :
                    neg_ovf ? 4'b1000 :
                              shifted[3:0];

  assign in_ready  = (state == ACC);
  assign take_term = in_valid & in_ready;
  assign last_term = (count == LAST_IDX);

  // Term collection, result hand-off and flush; flush overrides both a term
  // acceptance and a downstream consume in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      acc       <= '0;
      count     <= '0;
      out_code  <= 4'b0000;
      out_valid <= 1'b0;
    end else if (flush) begin
      state     <= ACC;
      acc       <= '0;
      count     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (take_term) begin
            if (last_term) begin
              out_code  <= sat_code;
              out_valid <= 1'b1;
              acc       <= '0;
              count     <= '0;
              state     <= HOLD;
            end else begin
              acc   <= sum;
              count <= count + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: begin
          state     <= ACC;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tanh_4bit_preact_accum.md
TANH_4BIT_PREACT_ACCUM -- requirements
Module: tanh_4bit_preact_accum

Interface
REQ-001 SHALL have parameter N_TERMS, default 4, giving the number of weighted terms per output (range 2..64).
REQ-002 SHALL have parameter ACC_W, default 10, giving the signed accumulator width; it must be at least 8+clog2(N_TERMS).
REQ-003 SHALL have parameter SHIFT, default 4, giving the arithmetic right shift applied before quantisation.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, with all state rising-edge triggered.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port flush, input, 1 bit: synchronous abort of the current vector.
REQ-007 SHALL have port in_valid, input, 1 bit: the term on x/w is valid.
REQ-008 SHALL have port in_ready, output, 1 bit: the block accepts a term this cycle.
REQ-009 SHALL have port x, input, 4 bits: unsigned activation operand, 0..15.
REQ-010 SHALL have port w, input, 4 bits: two's-complement weight, -8..7.
REQ-011 SHALL have port out_valid, output, 1 bit: out_code holds a finished pre-activation.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream 4-bit tanh stage consumes out_code.
REQ-013 SHALL have port out_code, output, 4 bits: saturated two's-complement pre-activation, -8..7, that feeds the tanh input bus directly.

Function
REQ-014 SHALL implement two states:
- ACC: collecting terms; in_ready=1, out_valid=0.
- HOLD: result pending; in_ready=0, out_valid=1.
REQ-015 SHALL accept a term only on a rising edge where in_valid=1 and in_ready=1; the term is p = x*w as a signed 8-bit product, sign-extended to ACC_W.
REQ-016 SHALL maintain a term counter of width clog2(N_TERMS) and a signed accumulator acc.
- Each non-final accepted term: acc<=acc+p, count<=count+1.
REQ-017 SHALL handle the final term (count==N_TERMS-1) at the accepting edge as follows:
- Compute s = acc+p.
- out_code <= sat4(s >>> SHIFT).
- acc<=0, count<=0, state<=HOLD.
- Latency: out_valid is high in the cycle immediately after the final term is accepted.
REQ-018 SHALL define sat4 as follows: arithmetic shift (floor toward minus infinity, no rounding); values above 7 give 0111; values below -8 give 1000; otherwise the low 4 bits.
REQ-019 SHALL never wrap the accumulator within one vector, given the ACC_W constraint in REQ-002.
REQ-020 SHALL, in HOLD, keep out_code and out_valid stable until out_ready=1; on that edge the state returns to ACC and in_ready is high in the next cycle.
REQ-021 SHALL ignore in_valid while in HOLD: no term is consumed and acc is unchanged.
REQ-022 SHALL, when flush=1 at an edge in either state, set acc<=0, count<=0, state<=ACC and out_valid<=0; out_code keeps its last value.
REQ-023 SHALL give flush priority over a simultaneous term acceptance (the term is dropped) and over a simultaneous out_ready (the result is dropped, and this is not counted as a transfer).
REQ-024 SHALL drive out_code only from a register, with no combinational path from x/w to out_code.
REQ-025 SHALL be fully synchronous to clk, apart from rst_n.

Reset
REQ-026 SHALL, while rst_n=0 (asynchronous, regardless of clk): state=ACC, acc=0, count=0, out_code=0000, out_valid=0, in_ready=1.
REQ-027 SHALL, on reset asserted mid-vector or in HOLD, discard all partial terms and any pending result; the first term accepted after rst_n deasserts is term 0 of a new vector.
REQ-028 SHALL use only synchronously timed logic after rst_n is released; the bench releases rst_n away from a clk edge.

Verification
REQ-029 SHALL cover: reset asserted -> out_valid=0, in_ready=1, out_code=0000; deassert, idle 3 cycles -> no change.
REQ-030 SHALL cover: 4 terms x=15,w=7 back-to-back (sum 420, >>>4=26) -> out_valid=1 one cycle after the 4th term, out_code=0111 (positive saturation).
REQ-031 SHALL cover: 4 terms x=1,w=-8 (sum -32, >>>4=-2) -> out_code=1110; then terms (3,2),(5,1),(2,3),(1,-1) (sum 16) -> out_code=0001.
REQ-032 SHALL cover: result pending with out_ready=0 for 5 cycles and in_valid=1 throughout -> out_code/out_valid stable, in_ready=0, no term consumed; out_ready=1 -> in_ready=1 next cycle.
REQ-033 SHALL cover: 2 terms (15,7), then flush together with in_valid, then 4 terms x=15,w=-8 (sum -480, >>>4=-30) -> out_code=1000, confirming the earlier terms and the flushed term were discarded.
REQ-034 SHALL cover: rst_n pulsed low after 3 terms, then 4 terms (3,2),(5,1),(2,3),(1,-1) -> out_code=0001 with no contribution from pre-reset terms.
